// File: rtl/buyruk_getirme.sv
// Instruction prefetch unit: issues word-aligned fetch requests to memory,
// queues in-order responses in a small FIFO of {address, instruction} pairs,
// and handles redirects by flushing the FIFO and discarding stale responses.
module buyruk_getirme #(
    parameter int          DERINLIK     = 4,
    parameter logic [31:0] BASLANGIC_PS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        bellek_istek,
    output logic [31:0] bellek_adres,
    input  logic        bellek_hazir,
    input  logic        bellek_yanit_gecerli,
    input  logic [31:0] bellek_veri,
    output logic        buyruk_gecerli,
    output logic [31:0] buyruk,
    output logic [31:0] buyruk_ps,
    input  logic        buyruk_hazir,
    input  logic        dallan,
    input  logic [31:0] dallan_adres
);

    localparam int PW = $clog2(DERINLIK);
    localparam int CW = $clog2(DERINLIK + 1);
    localparam logic [CW:0] DERIN_C = (CW + 1)'(DERINLIK);

    // Architectural state
    logic [31:0]   ps_reg, ps_next;
    logic [CW-1:0] bekleyen_reg, bekleyen_next;
    logic [CW-1:0] eski_reg, eski_next;
    logic [CW-1:0] dolu_reg, dolu_next;
    logic [PW-1:0] if_wr_reg, if_wr_next, if_rd_reg, if_rd_next;
    logic [PW-1:0] ff_wr_reg, ff_wr_next, ff_rd_reg, ff_rd_next;

    // In-flight address queue and instruction FIFO storage
    logic [31:0] if_adres_mem  [DERINLIK];
    logic [31:0] ff_ps_mem     [DERINLIK];
    logic [31:0] ff_buyruk_mem [DERINLIK];

    logic [CW:0] toplam;
    logic        kabul, yanit, atla, yaz, oku;
    logic        unused_bits;

    // The low two bits of a redirect target are forced to zero.
    assign unused_bits = ^dallan_adres[1:0];

    // Request credit: FIFO occupancy plus outstanding requests must stay below
    // depth so every response is guaranteed a FIFO slot. Gated by rst so the
    // request line drops immediately on asynchronous reset.
    assign toplam         = {1'b0, dolu_reg} + {1'b0, bekleyen_reg};
    assign bellek_istek   = rst && (toplam < DERIN_C) && !dallan;
    assign bellek_adres   = ps_reg;
    assign kabul          = bellek_istek && bellek_hazir;
    assign yanit          = bellek_yanit_gecerli;
    assign atla           = dallan || (eski_reg != '0);
    assign yaz            = yanit && !atla;
    assign buyruk_gecerli = (dolu_reg != '0);
    assign oku            = buyruk_gecerli && buyruk_hazir && !dallan;
    assign buyruk         = buyruk_gecerli ? ff_buyruk_mem[ff_rd_reg] : 32'h0;
    assign buyruk_ps      = buyruk_gecerli ? ff_ps_mem[ff_rd_reg]     : 32'h0;

    // Next-state computation for counters, pointers and fetch address
    always_comb begin
        ps_next       = ps_reg;
        bekleyen_next = bekleyen_reg + CW'(kabul) - CW'(yanit);
        eski_next     = eski_reg;
        dolu_next     = dolu_reg + CW'(yaz) - CW'(oku);
        if_wr_next    = kabul ? if_wr_reg + PW'(1) : if_wr_reg;
        if_rd_next    = yanit ? if_rd_reg + PW'(1) : if_rd_reg;
        ff_wr_next    = yaz   ? ff_wr_reg + PW'(1) : ff_wr_reg;
        ff_rd_next    = oku   ? ff_rd_reg + PW'(1) : ff_rd_reg;

        if (dallan) begin
            ps_next    = {dallan_adres[31:2], 2'b00};
            // Everything still outstanding after this cycle is stale; this
            // also covers a redirect arriving while older stale ones remain.
            eski_next  = bekleyen_reg - CW'(yanit);
            dolu_next  = '0;
            ff_wr_next = '0;
            ff_rd_next = '0;
        end else begin
            if (kabul) begin
                ps_next = ps_reg + 32'd4;
            end
            if (yanit && (eski_reg != '0)) begin
                eski_next = eski_reg - CW'(1);
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_reg       <= {BASLANGIC_PS[31:2], 2'b00};
            bekleyen_reg <= '0;
            eski_reg     <= '0;
            dolu_reg     <= '0;
            if_wr_reg    <= '0;
            if_rd_reg    <= '0;
            ff_wr_reg    <= '0;
            ff_rd_reg    <= '0;
        end else begin
            ps_reg       <= ps_next;
            bekleyen_reg <= bekleyen_next;
            eski_reg     <= eski_next;
            dolu_reg     <= dolu_next;
            if_wr_reg    <= if_wr_next;
            if_rd_reg    <= if_rd_next;
            ff_wr_reg    <= ff_wr_next;
            ff_rd_reg    <= ff_rd_next;
        end
    end

    // Storage writes: record accepted addresses, store kept responses
    always_ff @(posedge clk) begin
        if (kabul) begin
            if_adres_mem[if_wr_reg] <= ps_reg;
        end
        if (yaz) begin
            ff_ps_mem[ff_wr_reg]     <= if_adres_mem[if_rd_reg];
            ff_buyruk_mem[ff_wr_reg] <= bellek_veri;
        end
    end

endmodule

// File: tb/tb_buyruk_getirme.sv
// Self-checking bench for buyruk_getirme: memory model with configurable
// latency, a stream scoreboard, directed scenarios and a randomized run.
module tb_buyruk_getirme;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bellek_istek, bellek_hazir, bellek_yanit_gecerli;
    logic [31:0] bellek_adres, bellek_veri;
    logic        buyruk_gecerli, buyruk_hazir, dallan;
    logic [31:0] buyruk, buyruk_ps, dallan_adres;

    // Second instance: wrap-around start address, no responses
    logic        istek2, hazir2, yanit2, gecerli2, bhazir2, dallan2;
    logic [31:0] adres2, veri2, buyruk2, buyruk_ps2, dadres2;

    always #5 clk = ~clk;

    buyruk_getirme #(.DERINLIK(4), .BASLANGIC_PS(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst),
        .bellek_istek(bellek_istek), .bellek_adres(bellek_adres),
        .bellek_hazir(bellek_hazir), .bellek_yanit_gecerli(bellek_yanit_gecerli),
        .bellek_veri(bellek_veri), .buyruk_gecerli(buyruk_gecerli),
        .buyruk(buyruk), .buyruk_ps(buyruk_ps), .buyruk_hazir(buyruk_hazir),
        .dallan(dallan), .dallan_adres(dallan_adres)
    );

    buyruk_getirme #(.DERINLIK(4), .BASLANGIC_PS(32'hFFFF_FFF8)) u_dut2 (
        .clk(clk), .rst(rst),
        .bellek_istek(istek2), .bellek_adres(adres2),
        .bellek_hazir(hazir2), .bellek_yanit_gecerli(yanit2),
        .bellek_veri(veri2), .buyruk_gecerli(gecerli2),
        .buyruk(buyruk2), .buyruk_ps(buyruk_ps2), .buyruk_hazir(bhazir2),
        .dallan(dallan2), .dallan_adres(dadres2)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int lat          = 1;
    bit gap_en       = 1'b0;
    int pops         = 0;
    logic [31:0] exp_req, exp_ps;

    typedef struct {
        int          due;
        logic [31:0] adr;
    } ist_t;
    ist_t q[$];

    // Program image: three fixed words, hashed contents elsewhere
    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0:   word = 32'h0050_0093;
            32'h4:   word = 32'h0070_0113;
            32'h8:   word = 32'h0020_81b3;
            default: word = (a * 32'h9E37_79B1) ^ 32'h1357_2468;
        endcase
    endfunction

    // Memory model: note accepts and consumed responses mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            if (bellek_yanit_gecerli && q.size() > 0) void'(q.pop_front());
            if (bellek_istek && bellek_hazir) q.push_back('{cyc + lat, bellek_adres});
        end
    end

    // Memory model: present the oldest due response just after the edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst && q.size() > 0 && q[0].due <= cyc && !(gap_en && $urandom_range(0, 3) == 0)) begin
            bellek_yanit_gecerli = 1'b1;
            bellek_veri          = word(q[0].adr);
        end else begin
            bellek_yanit_gecerli = 1'b0;
            bellek_veri          = 32'h0;
        end
    end

    // Scoreboard: request addresses and delivered pairs follow a linear stream
    always @(negedge clk) begin
        if (rst) begin
            if (dallan) begin
                tests_run++;
                if (bellek_istek !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL istek_during_dallan: got %b expected 0", bellek_istek);
                end
                exp_req = {dallan_adres[31:2], 2'b00};
                exp_ps  = exp_req;
            end else begin
                if (bellek_istek && bellek_hazir) begin
                    tests_run++;
                    if (bellek_adres !== exp_req) begin
                        tests_failed++;
                        $display("FAIL req_addr: got %h expected %h", bellek_adres, exp_req);
                    end
                    exp_req += 32'd4;
                end
                if (buyruk_gecerli && buyruk_hazir) begin
                    tests_run++;
                    if (buyruk_ps !== exp_ps || buyruk !== word(exp_ps)) begin
                        tests_failed++;
                        $display("FAIL out_pair: got (%h,%h) expected (%h,%h)",
                                 buyruk_ps, buyruk, exp_ps, word(exp_ps));
                    end
                    exp_ps += 32'd4;
                    pops++;
                end
            end
        end
    end

    task automatic assert_reset();
        rst                  = 1'b0;
        q.delete();
        bellek_yanit_gecerli = 1'b0;
        bellek_veri          = 32'h0;
        bellek_hazir         = 1'b1;
        buyruk_hazir         = 1'b1;
        dallan               = 1'b0;
        dallan_adres         = 32'h0;
        lat                  = 1;
        gap_en               = 1'b0;
        exp_req              = 32'h0;
        exp_ps               = 32'h0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        assert_reset();
        #1;
        tests_run++;
        if (bellek_istek !== 1'b0 || buyruk_gecerli !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valids: got istek=%b gecerli=%b expected 0 0", bellek_istek, buyruk_gecerli);
        end
        tests_run++;
        if (buyruk !== 32'h0 || buyruk_ps !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_head: got (%h,%h) expected (0,0)", buyruk_ps, buyruk);
        end
        tests_run++;
        if (bellek_adres !== 32'h0 || adres2 !== 32'hFFFF_FFF8 || istek2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ps: got %h/%h istek2=%b expected 00000000/fffffff8 0", bellek_adres, adres2, istek2);
        end
        release_reset();
        @(negedge clk);
        tests_run++;
        if (bellek_istek !== 1'b1 || bellek_adres !== 32'h0) begin
            tests_failed++;
            $display("FAIL first_request: got istek=%b adres=%h expected 1 00000000", bellek_istek, bellek_adres);
        end
        repeat (10) next_cycle();
    endtask

    task automatic test_program();
        logic [31:0] prog[3];
        int t_acc = -1;
        int t_v   = -1;
        prog[0] = 32'h0050_0093; prog[1] = 32'h0070_0113; prog[2] = 32'h0020_81b3;
        @(negedge clk); #1;
        assert_reset();
        release_reset();
        for (int i = 0; i < 20 && t_v < 0; i++) begin
            @(negedge clk);
            if (t_acc < 0 && bellek_istek && bellek_hazir) t_acc = cyc;
            if (buyruk_gecerli) t_v = cyc;
        end
        tests_run++;
        if (t_v < 0 || t_acc < 0 || (t_v - t_acc) != 2) begin
            tests_failed++;
            $display("FAIL prog_latency: got %0d cycles expected 2", t_v - t_acc);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (buyruk_gecerli !== 1'b1 || buyruk_ps !== 32'(4 * k) || buyruk !== prog[k]) begin
                tests_failed++;
                $display("FAIL prog_pair%0d: got v=%b (%h,%h) expected 1 (%h,%h)",
                         k, buyruk_gecerli, buyruk_ps, buyruk, 32'(4 * k), prog[k]);
            end
        end
        repeat (10) next_cycle();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        @(negedge clk); #1;
        assert_reset();
        buyruk_hazir = 1'b0;
        release_reset();
        repeat (12) begin
            @(negedge clk);
            if (bellek_istek && bellek_hazir) acc++;
        end
        tests_run++;
        if (acc != 4 || bellek_istek !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_accepts: got %0d istek=%b expected 4 0", acc, bellek_istek);
        end
        tests_run++;
        if (buyruk_gecerli !== 1'b1 || buyruk_ps !== 32'h0) begin
            tests_failed++;
            $display("FAIL bp_head: got v=%b ps=%h expected 1 00000000", buyruk_gecerli, buyruk_ps);
        end
        next_cycle();
        buyruk_hazir = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bellek_istek !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_resume_early: got istek=%b expected 0", bellek_istek);
        end
        @(negedge clk);
        tests_run++;
        if (bellek_istek !== 1'b1 || bellek_adres !== 32'h10) begin
            tests_failed++;
            $display("FAIL bp_resume: got istek=%b adres=%h expected 1 00000010", bellek_istek, bellek_adres);
        end
        repeat (20) next_cycle();
    endtask

    task automatic test_redirect();
        int acc = 0;
        bit leak = 1'b0;
        @(negedge clk); #1;
        assert_reset();
        lat = 3;
        release_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bellek_istek && bellek_hazir) acc++;
            next_cycle();
        end
        tests_run++;
        if (acc != 3) begin
            tests_failed++;
            $display("FAIL redir_outstanding: got %0d expected 3", acc);
        end
        dallan       = 1'b1;
        dallan_adres = 32'h0000_0103;
        next_cycle();
        dallan       = 1'b0;
        dallan_adres = 32'h0;
        @(negedge clk);
        tests_run++;
        if (bellek_istek !== 1'b1 || bellek_adres !== 32'h100) begin
            tests_failed++;
            $display("FAIL redir_target: got istek=%b adres=%h expected 1 00000100", bellek_istek, bellek_adres);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (buyruk_gecerli !== 1'b0) leak = 1'b1;
        end
        tests_run++;
        if (leak) begin
            tests_failed++;
            $display("FAIL redir_stale: got a valid head before new data expected none");
        end
        @(negedge clk);
        tests_run++;
        if (buyruk_gecerli !== 1'b1 || buyruk_ps !== 32'h100 || buyruk !== word(32'h100)) begin
            tests_failed++;
            $display("FAIL redir_first: got v=%b (%h,%h) expected 1 (00000100,%h)",
                     buyruk_gecerli, buyruk_ps, buyruk, word(32'h100));
        end
        repeat (20) next_cycle();
    endtask

    task automatic test_async_reset();
        @(negedge clk); #1;
        assert_reset();
        lat = 3;
        release_reset();
        next_cycle();
        next_cycle();
        bellek_hazir = 1'b0;
        @(negedge clk); #2;
        tests_run++;
        if (bellek_adres !== 32'h8) begin
            tests_failed++;
            $display("FAIL arst_pre: got adres=%h expected 00000008", bellek_adres);
        end
        assert_reset();
        #1;
        tests_run++;
        if (bellek_istek !== 1'b0 || buyruk_gecerli !== 1'b0 || buyruk !== 32'h0 ||
            buyruk_ps !== 32'h0 || bellek_adres !== 32'h0) begin
            tests_failed++;
            $display("FAIL arst_outputs: got istek=%b v=%b (%h,%h) adres=%h expected 0 0 (0,0) 0",
                     bellek_istek, buyruk_gecerli, buyruk_ps, buyruk, bellek_adres);
        end
        release_reset();
        @(negedge clk);
        tests_run++;
        if (bellek_istek !== 1'b1 || bellek_adres !== 32'h0) begin
            tests_failed++;
            $display("FAIL arst_restart: got istek=%b adres=%h expected 1 00000000", bellek_istek, bellek_adres);
        end
        repeat (15) next_cycle();
    endtask

    task automatic test_wrap();
        logic [31:0] got[3];
        logic [31:0] want[3];
        int n = 0;
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        @(negedge clk); #1;
        assert_reset();
        buyruk_hazir = 1'b0;
        bellek_hazir = 1'b0;
        release_reset();
        for (int i = 0; i < 10 && n < 3; i++) begin
            @(negedge clk);
            if (istek2 && hazir2) begin
                got[n] = adres2;
                n++;
            end
        end
        tests_run++;
        if (n != 3) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d expected 3", n);
        end
        for (int k = 0; k < n; k++) begin
            tests_run++;
            if (got[k] !== want[k]) begin
                tests_failed++;
                $display("FAIL wrap_addr%0d: got %h expected %h", k, got[k], want[k]);
            end
        end
    endtask

    task automatic test_random();
        int pops0;
        @(negedge clk); #1;
        assert_reset();
        gap_en = 1'b1;
        release_reset();
        pops0 = pops;
        repeat (3000) begin
            next_cycle();
            buyruk_hazir = ($urandom_range(0, 3) != 0);
            bellek_hazir = ($urandom_range(0, 4) != 0);
            dallan       = ($urandom_range(0, 39) == 0);
            dallan_adres = $urandom;
            if ($urandom_range(0, 99) == 0) lat = $urandom_range(1, 4);
        end
        next_cycle();
        dallan = 1'b0;
        repeat (20) next_cycle();
        tests_run++;
        if (pops - pops0 < 200) begin
            tests_failed++;
            $display("FAIL random_progress: got %0d pops expected at least 200", pops - pops0);
        end
    endtask

    initial begin
        hazir2  = 1'b1;
        yanit2  = 1'b0;
        veri2   = 32'h0;
        bhazir2 = 1'b0;
        dallan2 = 1'b0;
        dadres2 = 32'h0;
        assert_reset();
        test_reset();
        test_program();
        test_backpressure();
        test_redirect();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
